// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC + 1-cycle sync imem, fetch-to-output latency 2 cycles; stall freezes outputs via a one-entry skid.
// Optional halt detection is enabled by defining HALT_DETECT_EN; redirect flushes and refetches.
module if_fetch_stage #(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruc_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               valid_out,
  output logic               halted
);

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {RUN, STALL, HALTED} state_e;
`else
  typedef enum logic [1:0] {RUN, STALL} state_e;
`endif

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 f_valid_q, f_valid_d;
  logic [ADDR_W-1:0]    f_addr_q, f_addr_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0]   skid_data_q, skid_data_d;
  logic [ADDR_W-1:0]    skid_addr_q, skid_addr_d;
  logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 halted_q, halted_d;

  logic                 fetch_go;
  logic [ADDR_W-1:0]    fetch_addr;
  logic                 load_vld;
  logic [INSTR_W-1:0]   load_data;
  logic [ADDR_W-1:0]    load_addr;

`ifndef HALT_DETECT_EN
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    f_valid_d    = f_valid_q;
    f_addr_d     = f_addr_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    out_valid_d  = out_valid_q;
    halted_d     = halted_q;
    fetch_go     = 1'b0;
    fetch_addr   = pc_q;
    load_vld     = 1'b0;
    load_data    = imem_data;
    load_addr    = f_addr_q;

    if (redirect) begin
      // The instruction returning this cycle is wrong-path and is dropped.
      fetch_go     = 1'b1;
      fetch_addr   = redirect_addr;
      f_valid_d    = 1'b1;
      f_addr_d     = redirect_addr;
      pc_d         = redirect_addr + ADDR_W'(1);
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      state_d      = RUN;
      halted_d     = 1'b0;
    end else begin
      case (state_q)
`ifdef HALT_DETECT_EN
        HALTED: begin
          f_valid_d   = 1'b0;
          out_valid_d = 1'b0;
        end
`endif
        default: begin
          if (stall) begin
            f_valid_d = 1'b0;
            if (f_valid_q) begin
              skid_valid_d = 1'b1;
              skid_data_d  = imem_data;
              skid_addr_d  = f_addr_q;
            end
            state_d = STALL;
          end else begin
            fetch_go  = 1'b1;
            f_valid_d = 1'b1;
            f_addr_d  = pc_q;
            pc_d      = pc_q + ADDR_W'(1);
            state_d   = RUN;
            if (state_q == STALL) begin
              load_vld     = skid_valid_q;
              load_data    = skid_data_q;
              load_addr    = skid_addr_q;
              skid_valid_d = 1'b0;
            end else begin
              load_vld = f_valid_q;
            end
            out_valid_d = load_vld;
            if (load_vld) begin
              out_instr_d = load_data;
              out_addr_d  = load_addr;
`ifdef HALT_DETECT_EN
              if (load_data[INSTR_W-1 -: 4] == HALT_OPCODE) begin
                state_d  = HALTED;
                halted_d = 1'b1;
              end
`endif
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      f_valid_q    <= 1'b0;
      f_addr_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_addr_q  <= '0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      f_valid_q    <= f_valid_d;
      f_addr_q     <= f_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      out_valid_q  <= out_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_en     = fetch_go & ~rst;
  assign imem_addr   = fetch_addr;
  assign instruc_out = out_instr_q;
  assign addr_out    = out_addr_q;
  assign valid_out   = out_valid_q;
`ifdef HALT_DETECT_EN
  assign halted      = halted_q;
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a synchronous instruction memory model.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [15:0] imem_data = 16'h0;
  logic [15:0] instruc_out;
  logic [7:0]  addr_out;
  logic        valid_out;
  logic        halted;

  logic [15:0] mem [256];
  int total = 0;
  int bad = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_data(imem_data), .instruc_out(instruc_out), .addr_out(addr_out),
    .valid_out(valid_out), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] a, input logic [15:0] d);
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    if (v) begin
      chk({tag, ".addr"}, 32'(addr_out), 32'(a));
      chk({tag, ".instr"}, 32'(instruc_out), 32'(d));
    end
  endtask

  task automatic chk_fetch(input string tag, input logic en, input logic [7:0] a);
    chk({tag, ".en"}, 32'(imem_en), 32'(en));
    if (en) chk({tag, ".addr"}, 32'(imem_addr), 32'(a));
  endtask

  task automatic cyc(input logic r, input logic s, input logic rd, input logic [7:0] ra);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_addr = ra;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h10] = 16'hF000;

    cyc(1, 0, 0, 8'h00);
    chk_out("reset", 1'b0, 8'h00, 16'h0);
    chk("reset.addr_out", 32'(addr_out), 32'h0);
    chk("reset.instr", 32'(instruc_out), 32'h0);
    chk("reset.halted", 32'(halted), 32'h0);
    chk("reset.en", 32'(imem_en), 32'h0);

    // cycle 0: first fetch at RESET_PC
    cyc(0, 0, 0, 8'h00);
    chk_fetch("c0", 1'b1, 8'h00);
    chk_out("c0", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00);
    chk_fetch("c1", 1'b1, 8'h01);
    chk_out("c1", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("c2", 1'b1, 8'h00, 16'h1000);
    cyc(0, 0, 0, 8'h00); chk_out("c3", 1'b1, 8'h01, 16'h1001);
    cyc(0, 0, 0, 8'h00); chk_out("c4", 1'b1, 8'h02, 16'h1002);
    cyc(0, 0, 0, 8'h00); chk_out("c5", 1'b1, 8'h03, 16'h1003);

    // stall 3 cycles with 05 in flight
    cyc(0, 1, 0, 8'h00); chk_out("stall0", 1'b1, 8'h04, 16'h1004); chk_fetch("stall0", 1'b0, 8'h00);
    cyc(0, 1, 0, 8'h00); chk_out("stall1", 1'b1, 8'h04, 16'h1004); chk_fetch("stall1", 1'b0, 8'h00);
    cyc(0, 1, 0, 8'h00); chk_out("stall2", 1'b1, 8'h04, 16'h1004); chk_fetch("stall2", 1'b0, 8'h00);
    cyc(0, 0, 0, 8'h00); chk_out("release", 1'b1, 8'h04, 16'h1004); chk_fetch("release", 1'b1, 8'h06);
    cyc(0, 0, 0, 8'h00); chk_out("skid", 1'b1, 8'h05, 16'h1005);
    cyc(0, 0, 0, 8'h00); chk_out("post_skid", 1'b1, 8'h06, 16'h1006);

    // redirect to 40
    cyc(0, 0, 1, 8'h40); chk_out("rd40.pre", 1'b1, 8'h07, 16'h1007); chk_fetch("rd40", 1'b1, 8'h40);
    cyc(0, 0, 0, 8'h00); chk_out("rd40.bubble", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("rd40.tgt", 1'b1, 8'h40, 16'h1040);

    // redirect together with stall, skid holding 42
    cyc(0, 1, 0, 8'h00); chk_out("rs.41", 1'b1, 8'h41, 16'h1041);
    cyc(0, 1, 1, 8'h20); chk_out("rs.hold", 1'b1, 8'h41, 16'h1041); chk_fetch("rs", 1'b1, 8'h20);
    cyc(0, 0, 0, 8'h00); chk_out("rs.bubble", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("rs.tgt", 1'b1, 8'h20, 16'h1020);

    // wrap around the top of the address space
    cyc(0, 0, 1, 8'hFE); chk_out("rs.next", 1'b1, 8'h21, 16'h1021);
    cyc(0, 0, 0, 8'h00); chk_out("wrap.bubble", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("wrap.FE", 1'b1, 8'hFE, 16'h10FE);
    cyc(0, 0, 0, 8'h00); chk_out("wrap.FF", 1'b1, 8'hFF, 16'h10FF);
    cyc(0, 0, 0, 8'h00); chk_out("wrap.00", 1'b1, 8'h00, 16'h1000);

    // run into the halt opcode at 10
    cyc(0, 0, 1, 8'h0E); chk_out("wrap.01", 1'b1, 8'h01, 16'h1001);
    cyc(0, 0, 0, 8'h00); chk_out("h.bubble", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("h.0E", 1'b1, 8'h0E, 16'h100E);
    cyc(0, 0, 0, 8'h00); chk_out("h.0F", 1'b1, 8'h0F, 16'h100F);
    cyc(0, 0, 0, 8'h00); chk_out("h.10", 1'b1, 8'h10, 16'hF000);
`ifdef HALT_DETECT_EN
    chk("h.halted", 32'(halted), 32'h1);
    chk_fetch("h.10", 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'(i % 2), 0, 8'h00);
      chk("hold.valid", 32'(valid_out), 32'h0);
      chk("hold.addr", 32'(addr_out), 32'h10);
      chk("hold.instr", 32'(instruc_out), 32'hF000);
      chk("hold.halted", 32'(halted), 32'h1);
      chk("hold.en", 32'(imem_en), 32'h0);
    end
    cyc(0, 0, 1, 8'h00); chk_fetch("resume", 1'b1, 8'h00);
    cyc(0, 0, 0, 8'h00); chk("resume.halted", 32'(halted), 32'h0); chk_out("resume.bubble", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("resume.00", 1'b1, 8'h00, 16'h1000);
`else
    chk("h.halted", 32'(halted), 32'h0);
    cyc(0, 0, 0, 8'h00); chk_out("h.11", 1'b1, 8'h11, 16'h1011); chk("h.halted2", 32'(halted), 32'h0);
    cyc(0, 0, 0, 8'h00); chk_out("h.12", 1'b1, 8'h12, 16'h1012);
`endif

    // reset overrides a simultaneous stall and redirect
    cyc(1, 1, 1, 8'h55);
    chk("rst.en", 32'(imem_en), 32'h0);
    cyc(0, 0, 0, 8'h00);
    chk_out("rst2", 1'b0, 8'h00, 16'h0);
    chk("rst2.addr_out", 32'(addr_out), 32'h0);
    chk("rst2.instr", 32'(instruc_out), 32'h0);
    chk("rst2.halted", 32'(halted), 32'h0);
    chk_fetch("rst2", 1'b1, 8'h00);
    cyc(0, 0, 0, 8'h00); chk_out("rst2.c1", 1'b0, 8'h00, 16'h0);
    cyc(0, 0, 0, 8'h00); chk_out("rst2.c2", 1'b1, 8'h00, 16'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
